// File: rtl/motor_adc_pkg.sv
// motor_adc_pkg
// Shared definitions for the motor ADC sample-processing blocks.
//   ADC_BITS    : width of the unsigned ADC code carried in each stream beat
//   AXIS_DATA_W : width of the AXI4-Stream tdata bus on both sides
//   outState_t  : state of the single-entry averaged-output holding register
package motor_adc_pkg;

  localparam int ADC_BITS    = 12;
  localparam int AXIS_DATA_W = 16;

  // EMPTY means no averaged beat is waiting; FULL means one is offered downstream.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } outState_t;

endpackage

// File: rtl/ocp_monitor.sv
// ocp_monitor
// Over-threshold monitor on raw ADC samples. Counts consecutive accepted samples
// strictly above the threshold and latches a sticky fault once the run length
// reaches TRIP_COUNT.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   accept     : a sample is being consumed this cycle
//   sample     : raw 12-bit ADC code of that sample
//   threshold  : trip level; a sample must exceed it to count
//   faultClr   : single-cycle clear of fault and run counter
//   fault      : latched over-threshold fault
module ocp_monitor
  import motor_adc_pkg::*;
#(
  parameter int TRIP_COUNT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                accept,
  input  logic [ADC_BITS-1:0] sample,
  input  logic [ADC_BITS-1:0] threshold,
  input  logic                faultClr,
  output logic                fault
);

  localparam logic [3:0] TRIP_LIM = 4'(TRIP_COUNT);

  logic [3:0] tripCnt;
  logic       overThreshold;
  logic       tripEvent;
  logic [3:0] tripCntInc;

  // A trip is the accepted over-threshold sample that moves the run counter
  // from TRIP_COUNT-1 to TRIP_COUNT. Once saturated, further over-threshold
  // samples keep the counter pinned without re-triggering.
  always_comb begin
    overThreshold = sample > threshold;
    tripEvent     = accept && overThreshold && (tripCnt == TRIP_LIM - 4'd1);
    tripCntInc    = (tripCnt == TRIP_LIM) ? TRIP_LIM : tripCnt + 4'd1;
  end

  // The trip takes priority over a coinciding clear so a real overcurrent
  // event can never be masked by a clear pulse issued in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tripCnt <= 4'd0;
      fault   <= 1'b0;
    end else if (tripEvent) begin
      tripCnt <= TRIP_LIM;
      fault   <= 1'b1;
    end else if (faultClr) begin
      tripCnt <= 4'd0;
      fault   <= 1'b0;
    end else if (accept) begin
      tripCnt <= overThreshold ? tripCntInc : 4'd0;
    end
  end

endmodule

// File: rtl/adc_avg_ocp.sv
// adc_avg_ocp
// Decimating boxcar averager over 2^LOG2_AVG accepted ADC samples, with a
// parallel over-threshold (overcurrent) monitor on the raw samples.
// Ports:
//   clk, rst_n      : clock and asynchronous active-low reset
//   s_axis_*        : raw sample stream; tdata[11:0] is the ADC code, tlast ignored
//   m_axis_*        : averaged stream, one-beat packets, tdata = {4'b0, avg}
//   trip_threshold  : fault level, compared against every accepted sample
//   fault_clr       : single-cycle synchronous fault clear
//   fault           : latched over-threshold fault
module adc_avg_ocp
  import motor_adc_pkg::*;
#(
  parameter int LOG2_AVG   = 3,
  parameter int TRIP_COUNT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [AXIS_DATA_W-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic [AXIS_DATA_W-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  input  logic [ADC_BITS-1:0]    trip_threshold,
  input  logic                   fault_clr,
  output logic                   fault
);

  localparam int ACC_W = ADC_BITS + LOG2_AVG;

  logic [ADC_BITS-1:0] sample;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    windowSum;
  logic [LOG2_AVG-1:0] winCnt;
  logic                lastSlot;
  logic                accept;
  logic                lastAccept;
  outState_t           state;
  outState_t           nextState;
  logic                unusedInputs;

  assign unusedInputs = ^{s_axis_tlast, s_axis_tdata[AXIS_DATA_W-1:ADC_BITS]};

  // Only the closing sample of a window needs the output register, so only it
  // stalls while an averaged beat is still waiting downstream.
  always_comb begin
    sample        = s_axis_tdata[ADC_BITS-1:0];
    windowSum     = acc + ACC_W'(sample);
    lastSlot      = (winCnt == '1);
    s_axis_tready = !(lastSlot && m_axis_tvalid && !m_axis_tready);
    accept        = s_axis_tvalid && s_axis_tready;
    lastAccept    = accept && lastSlot;
  end

  // Accumulator is wide enough for a full window of max codes, so it never
  // wraps; it restarts from zero as the closing sample is folded into the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      winCnt <= '0;
    end else if (lastAccept) begin
      acc    <= '0;
      winCnt <= '0;
    end else if (accept) begin
      acc    <= windowSum;
      winCnt <= winCnt + 1'b1;
    end
  end

  // The output data register only loads on a closing accept; that accept is
  // impossible while a beat is pending and not being taken, so data stays
  // stable for the whole time valid is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tdata <= '0;
    end else if (lastAccept) begin
      m_axis_tdata <= {{(AXIS_DATA_W-ADC_BITS){1'b0}}, windowSum[ACC_W-1:LOG2_AVG]};
    end
  end

  // Output holding-register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= nextState;
    end
  end

  // A new closing accept always leaves the register FULL, whether it was empty
  // or its previous beat is being taken in the same cycle.
  always_comb begin
    nextState     = state;
    m_axis_tvalid = 1'b0;
    case (state)
      EMPTY: begin
        if (lastAccept) nextState = FULL;
      end
      FULL: begin
        m_axis_tvalid = 1'b1;
        if (!lastAccept && m_axis_tready) nextState = EMPTY;
      end
      default: nextState = EMPTY;
    endcase
    m_axis_tlast = m_axis_tvalid;
  end

  ocp_monitor #(
    .TRIP_COUNT(TRIP_COUNT)
  ) uOcpMonitor (
    .clk      (clk),
    .rst_n    (rst_n),
    .accept   (accept),
    .sample   (sample),
    .threshold(trip_threshold),
    .faultClr (fault_clr),
    .fault    (fault)
  );

endmodule

// File: tb/tb_adc_avg_ocp.sv
// tb_adc_avg_ocp
// Self-checking bench for adc_avg_ocp: directed scenarios followed by
// randomized traffic, all compared against a behavioural window/fault model.
module tb_adc_avg_ocp;

  localparam int LOG2_AVG   = 3;
  localparam int TRIP_COUNT = 4;
  localparam int N          = 1 << LOG2_AVG;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [11:0] trip_threshold;
  logic        fault_clr;
  logic        fault;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: samples of the open window, the pending averaged beat,
  // the current over-threshold run length and the latched fault.
  int winQ[$];
  bit mdlValid;
  int mdlData;
  int mdlRun;
  bit mdlFault;
  bit mdlReady;
  bit sawReady;

  adc_avg_ocp #(
    .LOG2_AVG  (LOG2_AVG),
    .TRIP_COUNT(TRIP_COUNT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .trip_threshold(trip_threshold),
    .fault_clr     (fault_clr),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    winQ.delete();
    mdlValid = 1'b0;
    mdlData  = 0;
    mdlRun   = 0;
    mdlFault = 1'b0;
  endtask

  function automatic bit modelReady();
    return !(winQ.size() == N - 1 && mdlValid && !m_axis_tready);
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic modelClock(input bit ready);
    int  smp;
    int  sum;
    bit  accepted;
    bit  over;
    smp      = int'(s_axis_tdata[11:0]);
    accepted = s_axis_tvalid && ready;
    over     = smp > int'(trip_threshold);
    if (accepted && winQ.size() == N - 1) begin
      sum = smp;
      foreach (winQ[i]) sum += winQ[i];
      mdlData  = sum / N;
      mdlValid = 1'b1;
      winQ.delete();
    end else begin
      if (accepted) winQ.push_back(smp);
      if (mdlValid && m_axis_tready) mdlValid = 1'b0;
    end
    if (accepted && over && mdlRun == TRIP_COUNT - 1) begin
      mdlFault = 1'b1;
      mdlRun   = TRIP_COUNT;
    end else if (fault_clr) begin
      mdlFault = 1'b0;
      mdlRun   = 0;
    end else if (accepted) begin
      mdlRun = over ? ((mdlRun < TRIP_COUNT) ? mdlRun + 1 : TRIP_COUNT) : 0;
    end
  endtask

  task automatic compareModel();
    checkOutput("tvalid", m_axis_tvalid, mdlValid);
    checkOutput("tlast", m_axis_tlast, mdlValid);
    checkOutput("tdata", m_axis_tdata, mdlData);
    checkOutput("sReady", s_axis_tready, mdlReady);
    checkOutput("fault", fault, mdlFault);
  endtask

  // Drive one cycle of inputs from a negedge, check, clock, and return at the next negedge.
  task automatic applyStimulus(input logic [15:0] data, input bit valid, input bit mRdy, input bit clr);
    s_axis_tdata  = data;
    s_axis_tvalid = valid;
    s_axis_tlast  = data[0];
    m_axis_tready = mRdy;
    fault_clr     = clr;
    #1;
    mdlReady = modelReady();
    sawReady = s_axis_tready;
    compareModel();
    @(posedge clk);
    modelClock(mdlReady);
    @(negedge clk);
  endtask

  // Hold reset for a few cycles while offering data that must be ignored.
  task automatic resetDut(input int cycles);
    rst_n         = 1'b0;
    s_axis_tdata  = 16'd4000;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    fault_clr     = 1'b0;
    modelReset();
    for (int c = 0; c < cycles; c++) begin
      #1;
      mdlReady = 1'b1;
      compareModel();
      checkOutput("rstValid", m_axis_tvalid, 0);
      checkOutput("rstFault", fault, 0);
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b1;
    s_axis_tvalid = 1'b0;
  endtask

  initial begin
    int tripSeq[8];
    rst_n          = 1'b0;
    s_axis_tdata   = '0;
    s_axis_tvalid  = 1'b0;
    s_axis_tlast   = 1'b0;
    m_axis_tready  = 1'b1;
    trip_threshold = 12'hFFF;
    fault_clr      = 1'b0;
    modelReset();
    @(negedge clk);
    resetDut(2);

    for (int i = 0; i < N; i++) applyStimulus(16'(100 + i), 1'b1, 1'b1, 1'b0);
    checkOutput("basicAvg", m_axis_tdata, 32'h0067);
    checkOutput("basicValid", m_axis_tvalid, 1);
    checkOutput("basicLast", m_axis_tlast, 1);
    applyStimulus(16'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("basicDrain", m_axis_tvalid, 0);

    for (int i = 0; i < N; i++) applyStimulus(16'hFFFF, 1'b1, 1'b1, 1'b0);
    checkOutput("upperBits", m_axis_tdata, 32'h0FFF);
    applyStimulus(16'd0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < N; i++) applyStimulus(16'd10, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < N - 1; i++) applyStimulus(16'd20, 1'b1, 1'b0, 1'b0);
    checkOutput("bpHoldData", m_axis_tdata, 32'h000A);
    applyStimulus(16'd20, 1'b1, 1'b0, 1'b0);
    checkOutput("bpStall", sawReady, 0);
    checkOutput("bpStillData", m_axis_tdata, 32'h000A);
    applyStimulus(16'd20, 1'b1, 1'b1, 1'b0);
    checkOutput("bpNewData", m_axis_tdata, 32'h0014);
    checkOutput("bpValidKept", m_axis_tvalid, 1);
    applyStimulus(16'd0, 1'b0, 1'b1, 1'b0);

    trip_threshold = 12'd2000;
    tripSeq = '{2001, 2001, 2001, 1999, 2001, 2001, 2001, 2001};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(16'(tripSeq[i]), 1'b1, 1'b1, 1'b0);
      if (i < 7) checkOutput("tripEarly", fault, 0);
    end
    checkOutput("tripSet", fault, 1);
    applyStimulus(16'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("clrAlone", fault, 0);
    for (int i = 0; i < 10; i++) applyStimulus(16'd2000, 1'b1, 1'b1, 1'b0);
    checkOutput("equalNoTrip", fault, 0);
    for (int i = 0; i < TRIP_COUNT - 1; i++) applyStimulus(16'd2500, 1'b1, 1'b1, 1'b0);
    applyStimulus(16'd2500, 1'b1, 1'b1, 1'b1);
    checkOutput("tripBeatsClr", fault, 1);

    for (int i = 0; i < 5; i++) applyStimulus(16'd4000, 1'b1, 1'b1, 1'b0);
    resetDut(2);
    for (int i = 0; i < N; i++) applyStimulus(16'd8, 1'b1, 1'b1, 1'b0);
    checkOutput("postRstAvg", m_axis_tdata, 32'h0008);
    checkOutput("postRstValid", m_axis_tvalid, 1);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0) trip_threshold = 12'($urandom_range(1500, 3500));
      if ($urandom_range(0, 599) == 0) begin
        resetDut(1);
      end else begin
        applyStimulus({4'($urandom), 12'($urandom_range(1000, 4095))},
                      $urandom_range(0, 3) != 0,
                      $urandom_range(0, 2) != 0,
                      $urandom_range(0, 29) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
